// File: rtl/machine_pkg.sv
// Shared constants for the machine run/step controller: FSM encoding,
// display select codes and front-panel button indices.
package machine_pkg;

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [1:0] SEL_RESULT = 2'b00;
    localparam logic [1:0] SEL_PC     = 2'b01;
    localparam logic [1:0] SEL_INSTR  = 2'b10;
    localparam logic [1:0] SEL_STEPS  = 2'b11;

    localparam int NUM_BTN    = 5;
    localparam int BTN_STEP   = 0;
    localparam int BTN_RUN    = 1;
    localparam int BTN_CLR    = 2;
    localparam int BTN_SEL_LO = 3;
    localparam int BTN_SEL_HI = 4;

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button conditioner: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                // DEB_CYCLES consecutive differing samples: accept the new level.
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;
    assign press_o = r_press;

endmodule

// File: rtl/machine_step_ctrl.sv
// Run/step controller and registered display mux for the processor + ROM pair.
// Optional feature: define MACHINE_BRKPT_EN to add a PC breakpoint in RUN.
module machine_step_ctrl
    import machine_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               ADDR_W     = 2,
    parameter int               DEB_CYCLES = 50000,
    parameter int               RUN_DIV    = 1000,
    parameter logic [DATA_W-1:0] HALT_OP   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        btn,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] result_i,
`ifdef MACHINE_BRKPT_EN
    input  logic [ADDR_W-1:0] brk_addr_i,
    input  logic              brk_en_i,
`endif
    output logic              step_o,
    output logic [DATA_W-1:0] out,
    output logic              running_o,
    output logic              halted_o
);

    localparam int PRE_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [4:0]         w_unused_deb;
    logic [1:0]         w_sel;
    logic               w_is_halt;
    logic               w_run_tick;
    logic               w_brk_hit;
    logic [DATA_W-1:0]  w_out_next;

    logic [1:0]         r_state;
    logic [PRE_W-1:0]   r_presc;
    logic [DATA_W-1:0]  r_step_cnt;
    logic [DATA_W-1:0]  r_out;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (btn[gi]),
            .level_o (w_level[gi]),
            .press_o (w_press[gi])
        );
    end

    // Control buttons only need the pulse, select buttons only the level.
    assign w_unused_deb = {w_press[BTN_SEL_HI:BTN_SEL_LO], w_level[BTN_CLR:BTN_STEP]};
    assign w_sel        = w_level[BTN_SEL_HI:BTN_SEL_LO];
    assign w_is_halt    = (instr_i == HALT_OP);
    assign w_run_tick   = (r_presc == PRE_W'(RUN_DIV - 1));

`ifdef MACHINE_BRKPT_EN
    logic r_first;

    // The first step after leaving STOP is never blocked, so RUN can resume past a breakpoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b1;
        end else if (r_state != ST_RUN) begin
            r_first <= 1'b1;
        end else if (step_o) begin
            r_first <= 1'b0;
        end
    end

    assign w_brk_hit = brk_en_i && (pc_i == brk_addr_i) && !r_first;
`else
    assign w_brk_hit = 1'b0;
`endif

    assign step_o    = !w_is_halt &&
                       ((r_state == ST_STEP) ||
                        ((r_state == ST_RUN) && w_run_tick && !w_brk_hit));
    assign running_o = (r_state == ST_RUN);
    assign halted_o  = (r_state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
            r_presc <= '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (!w_press[BTN_CLR]) begin
                        if (w_press[BTN_RUN]) begin
                            r_state <= ST_RUN;
                        end else if (w_press[BTN_STEP]) begin
                            r_state <= ST_STEP;
                        end
                    end
                end
                ST_STEP: r_state <= w_is_halt ? ST_HALT : ST_STOP;
                ST_RUN: begin
                    if (w_is_halt) begin
                        r_state <= ST_HALT;
                        r_presc <= '0;
                    end else if (w_press[BTN_RUN] || (w_run_tick && w_brk_hit)) begin
                        r_state <= ST_STOP;
                        r_presc <= '0;
                    end else begin
                        r_presc <= w_run_tick ? '0 : r_presc + 1'b1;
                    end
                end
                ST_HALT: begin
                    if (w_press[BTN_CLR]) begin
                        r_state <= ST_STOP;
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves w_out_next unassigned (no latch).
        w_out_next = result_i;
        case (w_sel)
            SEL_RESULT: w_out_next = result_i;
            SEL_PC:     w_out_next = {{(DATA_W - ADDR_W){1'b0}}, pc_i};
            SEL_INSTR:  w_out_next = instr_i;
            SEL_STEPS:  w_out_next = r_step_cnt;
            default:    w_out_next = result_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_out      <= '0;
        end else begin
            r_out <= w_out_next;
            if (step_o) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign out = r_out;

endmodule
